// File: rtl/ds_link_tx.sv
// IEEE1355 DS-link character transmitter: serialises bytes as parity-protected
// data characters onto a data/strobe pair, filling idle gaps with NULLs.
module ds_link_tx #(
    parameter int unsigned G_LINK_PARITY_IS_ODD = 1,
    parameter int unsigned G_CLK_DIV            = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_en,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       d_out,
    output logic       s_out,
    output logic       busy
);

    localparam int unsigned CHAR_W  = 10;
    localparam int unsigned NULL_W  = 8;
    localparam int unsigned SHIFT_W = CHAR_W - 1;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned DIV_W   = 8;

    localparam logic             ODD        = (G_LINK_PARITY_IS_ODD != 0);
    localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(G_CLK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [SHIFT_W-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]   left_q,  left_d;
    logic [DIV_W-1:0]   div_q,   div_d;
    logic               d_q,     d_d;
    logic               s_q,     s_d;
    logic               busy_q,  busy_d;
    logic               hist_q,  hist_d;

    logic [CHAR_W-1:0]  char_bits;
    logic [CNT_W-1:0]   char_len;
    logic               emit;
    logic               emit_bit;
    logic               p_data;
    logic               p_esc;
    logic               p_fct;

    // hist_q is the XOR of the previous character's data/control bits.
    // The FCT inside a NULL follows ESC control bits 1,1, which cancel.
    assign p_data = ODD ^ hist_q;
    assign p_esc  = ~(ODD ^ hist_q);
    assign p_fct  = ~ODD;

    // Character image, bit 0 is the first bit on the line
    always_comb begin : build_char
        char_bits = '0;
        char_len  = CNT_W'(NULL_W);
        if (tx_valid) begin
            char_bits = {tx_data, 1'b0, p_data};
            char_len  = CNT_W'(CHAR_W);
        end else begin
            char_bits = {2'b00, 3'b001, p_fct, 3'b111, p_esc};
            char_len  = CNT_W'(NULL_W);
        end
    end

    always_comb begin : next_state
        state_d  = state_q;
        shreg_d  = shreg_q;
        left_d   = left_q;
        div_d    = div_q;
        d_d      = d_q;
        s_d      = s_q;
        busy_d   = busy_q;
        hist_d   = hist_q;
        emit     = 1'b0;
        emit_bit = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (tx_en) begin
                    state_d = S_LOAD;
                end
            end

            S_LOAD: begin
                emit     = 1'b1;
                emit_bit = char_bits[0];
                shreg_d  = char_bits[CHAR_W-1:1];
                left_d   = char_len - CNT_W'(1);
                div_d    = DIV_RELOAD;
                busy_d   = 1'b1;
                hist_d   = tx_valid ? (^tx_data) : 1'b0;
                state_d  = S_SHIFT;
            end

            S_SHIFT: begin
                if (div_q != '0) begin
                    div_d = div_q - DIV_W'(1);
                end else if (left_q != '0) begin
                    emit     = 1'b1;
                    emit_bit = shreg_q[0];
                    shreg_d  = {1'b0, shreg_q[SHIFT_W-1:1]};
                    left_d   = left_q - CNT_W'(1);
                    div_d    = DIV_RELOAD;
                end else begin
                    busy_d  = 1'b0;
                    state_d = tx_en ? S_LOAD : S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // DS encoding: strobe toggles only when the data line does not
        if (emit) begin
            d_d = emit_bit;
            s_d = (emit_bit == d_q) ? ~s_q : s_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : regs
        if (!rst_n) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
            left_q  <= '0;
            div_q   <= '0;
            d_q     <= 1'b0;
            s_q     <= 1'b0;
            busy_q  <= 1'b0;
            hist_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            left_q  <= left_d;
            div_q   <= div_d;
            d_q     <= d_d;
            s_q     <= s_d;
            busy_q  <= busy_d;
            hist_q  <= hist_d;
        end
    end

    // Accept strobe is only meaningful in the LOAD cycle, where the byte is taken
    assign tx_ready = (state_q == S_LOAD) && tx_valid;
    assign d_out    = d_q;
    assign s_out    = s_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_ds_link_tx.sv
// Directed bench for ds_link_tx: decodes the DS line pair back into bits and
// compares each character against hand-computed images.
module tb_ds_link_tx;

    localparam int unsigned DIV = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tx_en, tx_valid, tx_ready, d_out, s_out, busy;
    logic [7:0] tx_data;

    logic       e_en, e_valid, e_ready, e_d, e_s, e_busy;
    logic [7:0] e_data;

    always #5 clk = ~clk;

    ds_link_tx #(.G_LINK_PARITY_IS_ODD(1), .G_CLK_DIV(DIV)) dut (
        .clk(clk), .rst_n(rst_n), .tx_en(tx_en), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .d_out(d_out),
        .s_out(s_out), .busy(busy)
    );

    ds_link_tx #(.G_LINK_PARITY_IS_ODD(0), .G_CLK_DIV(1)) dut_even (
        .clk(clk), .rst_n(rst_n), .tx_en(e_en), .tx_data(e_data),
        .tx_valid(e_valid), .tx_ready(e_ready), .d_out(e_d),
        .s_out(e_s), .busy(e_busy)
    );

    typedef struct {
        logic        valid;
        logic [7:0]  data;
        int          len;
        logic [9:0]  bits;
    } vec_t;

    vec_t vt[12];

    int   errors = 0;
    int   checks = 0;
    logic pd, ps;
    logic bits[$];
    int   gaps[$];
    int   gap;
    int   rdy_pending;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock; sample after the edge and decode any DS transition into a bit
    task automatic step();
        @(posedge clk);
        #1;
        gap++;
        if (d_out !== pd || s_out !== ps) begin
            check("ds_one_line", 32'(d_out ^ pd ^ s_out ^ ps), 32'd1);
            bits.push_back(d_out);
            gaps.push_back(gap);
            gap = 0;
            pd  = d_out;
            ps  = s_out;
        end
    endtask

    task automatic resync();
        pd = d_out;
        ps = s_out;
        gap = 0;
        rdy_pending = 0;
        bits.delete();
        gaps.delete();
    endtask

    task automatic do_char(input string name, input logic valid, input int len,
                           input logic [9:0] exp, input int exp_wait,
                           input logic nvalid, input logic [7:0] ndata, input int drop_at);
        int         w;
        int         cnt;
        int         rdy;
        int         bad;
        logic [9:0] got;
        bits.delete();
        gaps.delete();
        w   = 0;
        rdy = rdy_pending;
        rdy_pending = 0;
        while (busy !== 1'b1 && w < 50) begin
            step();
            w++;
            if (tx_ready === 1'b1) rdy++;
        end
        check({name, "_wait"}, 32'(w), 32'(exp_wait));
        check({name, "_ready"}, 32'(rdy), 32'(valid));
        tx_valid = nvalid;
        tx_data  = ndata;
        cnt = 1;
        while (cnt < 200) begin
            step();
            if (busy !== 1'b1) break;
            cnt++;
            if (cnt == drop_at) tx_en = 1'b0;
        end
        rdy_pending = (tx_ready === 1'b1) ? 1 : 0;
        check({name, "_busy_len"}, 32'(cnt), 32'(len * int'(DIV)));
        check({name, "_nbits"}, 32'(bits.size()), 32'(len));
        got = '0;
        for (int i = 0; i < bits.size() && i < 10; i++) got[i] = bits[i];
        check({name, "_bits"}, 32'(got), 32'(exp));
        bad = 0;
        for (int i = 1; i < gaps.size(); i++) if (gaps[i] != int'(DIV)) bad++;
        check({name, "_bit_period"}, 32'(bad), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int         w;
        int         moves;
        logic [9:0] got;
        logic       d0, s0;

        vt[0]  = '{1'b0, 8'h55, 8,  10'h02E};
        vt[1]  = '{1'b1, 8'hE6, 10, 10'h399};
        vt[2]  = '{1'b1, 8'h2E, 10, 10'h0B8};
        vt[3]  = '{1'b1, 8'h3E, 10, 10'h0F9};
        vt[4]  = '{1'b0, 8'hAA, 8,  10'h02F};
        vt[5]  = '{1'b1, 8'h00, 10, 10'h001};
        vt[6]  = '{1'b1, 8'hFF, 10, 10'h3FD};
        vt[7]  = '{1'b1, 8'h01, 10, 10'h005};
        vt[8]  = '{1'b1, 8'h80, 10, 10'h200};
        vt[9]  = '{1'b0, 8'h00, 8,  10'h02F};
        vt[10] = '{1'b0, 8'hFF, 8,  10'h02E};
        vt[11] = '{1'b1, 8'h3E, 10, 10'h0F9};

        rst_n = 1'b0;
        tx_en = 1'b0; tx_valid = 1'b1; tx_data = 8'h11;
        e_en = 1'b0; e_valid = 1'b0; e_data = 8'h00;
        #23;
        check("rst_d", 32'(d_out), 32'd0);
        check("rst_s", 32'(s_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(tx_ready), 32'd0);
        #4 rst_n = 1'b1;
        resync();
        for (int i = 0; i < 3; i++) step();
        check("idle_ready", 32'(tx_ready), 32'd0);

        // Even-parity instance, one bit per clock: data 0x03 then a NULL
        e_valid = 1'b1; e_data = 8'h03; e_en = 1'b1;
        w = 0;
        while (e_busy !== 1'b1 && w < 10) begin step(); w++; end
        e_valid = 1'b0;
        got = '0;
        got[0] = e_d;
        for (int i = 1; i < 10; i++) begin step(); got[i] = e_d; end
        check("even_data", 32'(got), 32'h00C);
        step();
        check("even_load_busy", 32'(e_busy), 32'd0);
        step();
        got = '0;
        got[0] = e_d;
        for (int i = 1; i < 8; i++) begin step(); got[i] = e_d; end
        check("even_null", 32'(got), 32'h03F);
        e_en = 1'b0;
        for (int i = 0; i < 12; i++) step();

        // Back-to-back characters from the table, tx_en held high
        tx_valid = vt[0].valid;
        tx_data  = vt[0].data;
        tx_en    = 1'b1;
        for (int i = 0; i < 12; i++) begin
            do_char($sformatf("vec%0d", i), vt[i].valid, vt[i].len, vt[i].bits,
                    (i == 0) ? 2 : 1,
                    (i < 11) ? vt[i+1].valid : 1'b1,
                    (i < 11) ? vt[i+1].data  : 8'hA4, -1);
        end

        // tx_en dropped during bit 3: character completes, then the line goes quiet
        do_char("drop", 1'b1, 10, 10'h290, 1, 1'b1, 8'h5A, 3 * int'(DIV) + 2);
        d0 = d_out;
        s0 = s_out;
        moves = 0;
        for (int i = 0; i < 120; i++) begin
            step();
            if (d_out !== d0 || s_out !== s0 || tx_ready !== 1'b0 || busy !== 1'b0) moves++;
        end
        check("static_after_drop", 32'(moves), 32'd0);

        // Reset in the middle of a NULL whose parity history is 1
        tx_valid = 1'b0;
        tx_en    = 1'b1;
        bits.delete();
        w = 0;
        while (busy !== 1'b1 && w < 10) begin step(); w++; end
        for (int i = 0; i < 8; i++) step();
        check("null_hist1_p", 32'((bits.size() > 0) ? bits[0] : 1'b0), 32'd1);
        #2 rst_n = 1'b0;
        tx_en = 1'b0;
        #1;
        check("midrst_d", 32'(d_out), 32'd0);
        check("midrst_s", 32'(s_out), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        #13 rst_n = 1'b1;
        resync();
        step();
        tx_en = 1'b1;
        do_char("null_after_rst", 1'b0, 8, 10'h02E, 2, 1'b0, 8'h00, -1);
        tx_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ds_link_tx.md
Name: ds_link_tx

Overview:
IEEE1355 DS-link character transmitter for the FPGA node. It accepts bytes over a valid/ready interface and serialises them as data characters, with link parity and data-strobe encoding, onto d_out/s_out. When no byte is pending it fills the gap with NULL characters (ESC followed by FCT). It is the transmit-side counterpart of the node's DS receive path, and is verified against bfm_ieee1355 (fifo_rx side).

Parameters:
G_LINK_PARITY_IS_ODD, 1, 1 = odd link parity, 0 = even link parity.
G_CLK_DIV, 4, clk cycles per line bit; legal range 1..255 (at 100 MHz the default gives 25 Mb/s).

Ports:
clk       in   1  system clock; all logic on rising edge
rst_n     in   1  asynchronous active-low reset
tx_en     in   1  link enable; 0 = stop at the next character boundary
tx_data   in   8  byte to send
tx_valid  in   1  tx_data valid; held until accepted
tx_ready  out  1  single-cycle accept strobe; a byte transfers when tx_valid && tx_ready
d_out     out  1  DS data line
s_out     out  1  DS strobe line
busy      out  1  1 while a character is being shifted out

Behaviour:
- Reset (asynchronous, rst_n=0):
  - d_out=0, s_out=0, tx_ready=0, busy=0.
  - Parity history = 0; bit counter and divider cleared; state = IDLE.
- States:
  - IDLE -> LOAD when tx_en=1.
  - LOAD (one cycle) -> SHIFT.
  - SHIFT -> LOAD after the last bit, if tx_en=1.
  - SHIFT -> IDLE after the last bit, if tx_en=0.
- LOAD cycle:
  - If tx_valid=1: tx_ready=1 in this cycle, tx_data is latched, and a 10-bit data character is built.
  - Otherwise: tx_ready=0 and a NULL is built.
  - tx_ready is never asserted outside LOAD.
- Character formats, transmitted first bit to last:
  - Data character: P, 0, d0..d7 (LSB first).
  - ESC: P, 1, 1, 1.
  - FCT: P, 1, 0, 0.
  - NULL: ESC immediately followed by FCT, 8 bits total.
- Parity:
  - P covers the data or control bits of the preceding character plus the flag bit of its own character.
  - With G_LINK_PARITY_IS_ODD=1, P is chosen so that P ^ prev_bits ^ flag = 1; with G_LINK_PARITY_IS_ODD=0, that XOR = 0.
  - The FCT parity inside a NULL covers the ESC control bits (1,1).
  - prev_bits = 0 for the first character after reset. The history is retained across IDLE.
- DS encoding:
  - At each bit boundary, d_out takes the new bit.
  - If the new bit equals the previous d_out, s_out toggles; otherwise s_out holds.
  - Exactly one of d_out/s_out changes per bit boundary.
- Timing:
  - The first bit of a character appears on d_out/s_out on the clock edge ending the LOAD cycle.
  - Each bit is held for exactly G_CLK_DIV cycles.
  - busy=1 from the end of LOAD to the end of the last bit.
- Throughput with tx_valid held high:
  - One LOAD cycle per character, and no NULLs are inserted between bytes.
  - Character period = 10*G_CLK_DIV+1 cycles (data) or 8*G_CLK_DIV+1 cycles (NULL).
  - During LOAD, d_out/s_out hold their last value.
- tx_en deasserted mid-character: the current character, including both halves of a NULL, completes; the block then enters IDLE with d_out/s_out holding their last values.
- tx_valid deasserted before acceptance: the block sends a NULL and never accepts a partial byte.
- tx_data changing while the byte is not yet accepted: it has no effect until LOAD.
- Reset mid-character: outputs go to 0 immediately; no partial-character recovery.

Test Plan:
1. Reset, then tx_en=1 with tx_valid=0 -> first NULL bits 0,1,1,1,0,1,0,0 on d_out (odd parity). A continuous NULL stream follows, and exactly one line toggles every G_CLK_DIV cycles.
2. Send 5 bytes (0xE6, 0x2E, 0x2E, 0x3E, 0x3E) via DS loopback into bfm_ieee1355 -> BFM rx FIFO holds exactly those 5 bytes, in order, as data (not NULLs), with no parity error flagged.
3. 64 random bytes with tx_valid held high, G_CLK_DIV=4 -> tx_ready pulses every 41 cycles with no NULL between characters. All 64 bytes are checked at the BFM.
4. G_LINK_PARITY_IS_ODD=0 with a matching BFM -> 16 random bytes are received without error. A G_LINK_PARITY_IS_ODD=1 BFM against this transmitter flags a parity error on the first character.
5. Drop tx_en during bit 3 of a data character -> the character completes (10 bits) and busy falls. Outputs then stay static for at least 100 cycles, and tx_ready stays 0.
6. Assert rst_n=0 mid-NULL -> d_out=s_out=0 within the same cycle. After release and tx_en=1, the first NULL again shows parity computed from prev_bits=0.
